bpi_cmd_sequencer: RTL and testbench

//  Upstream stage of the BPI flash interface. Expands one high-level flash command
//  (read array, program word, erase block, lock/unlock, status) into the ordered

---
 rtl/bpi_cmd_sequencer.sv | 276 +++++++++++++++++++++++++++
 tb/tb_bpi_cmd_sequencer.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bpi_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// bpi_cmd_sequencer
//   Front end of the BPI flash interface. Takes one high-level flash command and
//   expands it into the ordered single-cycle bus operations (ADDR, CMD_DATA_OUT,
//   OP, EXECUTE) that the interface executes. Returns array read data, the flash
//   status register, a one-cycle DONE pulse and error flags.
//
// Ports
//   CLK, RST            clock, asynchronous active-high reset
//   CMD_VALID/CMD_RDY   command handshake (accepted when both are 1)
//   CMD_CODE            0 RD_ARRAY, 1 RD_STATUS, 2 PROGRAM, 3 ERASE, 4 UNLOCK,
//                       5 LOCK, 6 CLR_STATUS, 7 illegal
//   CMD_ADDR/DATA/CNT   start/block address, program data, array word count
//   ADDR, CMD_DATA_OUT, OP (01 write, 10 read), EXECUTE   to the interface
//   BPI_BUSY, LOAD_DATA, DATA_IN                          from the interface
//   RD_DATA/RD_VALID    array read word and its one-cycle qualifier
//   STATUS              last flash status register read
//   DONE/ERR            completion pulse; ERR[0] SR error, [1] poll timeout,
//                       [2] illegal code, [3] always 0
//
// state     | meaning
// ----------+---------------------------------------------------------------
// IDLE      | waiting for a command, CMD_RDY=1
// SETUP     | ADDR/CMD_DATA_OUT/OP hold the current step; wait for BUSY=0
// ISSUE     | EXECUTE asserted for the current step
// WAIT_ACK  | EXECUTE held until the interface raises BUSY
// WAIT_DONE | waiting for BUSY to fall
// NEXT      | advance step, repeat a poll/array read, or finish
// ILL       | illegal code, one dead cycle before FINISH
// FINISH    | DONE pulse with ERR valid, CMD_RDY=1
// -----------------------------------------------------------------------------
module bpi_cmd_sequencer #(
  parameter int CNT_W    = 11,
  parameter int POLL_MAX = 65535
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CMD_VALID,
  output logic             CMD_RDY,
  input  logic [2:0]       CMD_CODE,
  input  logic [22:0]      CMD_ADDR,
  input  logic [15:0]      CMD_DATA,
  input  logic [CNT_W-1:0] CMD_CNT,
  output logic [22:0]      ADDR,
  output logic [15:0]      CMD_DATA_OUT,
  output logic [1:0]       OP,
  output logic             EXECUTE,
  input  logic             BPI_BUSY,
  input  logic             LOAD_DATA,
  input  logic [15:0]      DATA_IN,
  output logic [15:0]      RD_DATA,
  output logic             RD_VALID,
  output logic [7:0]       STATUS,
  output logic             DONE,
  output logic [3:0]       ERR
);

  localparam int PW = (POLL_MAX < 2) ? 1 : $clog2(POLL_MAX + 1);

  localparam logic [2:0] C_RD_ARRAY   = 3'd0;
  localparam logic [2:0] C_RD_STATUS  = 3'd1;
  localparam logic [2:0] C_PROGRAM    = 3'd2;
  localparam logic [2:0] C_ERASE      = 3'd3;
  localparam logic [2:0] C_UNLOCK     = 3'd4;
  localparam logic [2:0] C_LOCK       = 3'd5;
  localparam logic [2:0] C_CLR_STATUS = 3'd6;
  localparam logic [2:0] C_ILLEGAL    = 3'd7;

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_W    = 2'b01;
  localparam logic [1:0] OP_R    = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_ISSUE,
    S_WAIT_ACK,
    S_WAIT_DONE,
    S_NEXT,
    S_ILL,
    S_FINISH
  } state_t;

  state_t             state_q, state_d;
  logic [2:0]         code_q;
  logic [2:0]         step_q, step_d;
  logic [22:0]        addr_q;
  logic [15:0]        data_q;
  logic [15:0]        dout_q;
  logic [1:0]         op_q;
  logic [CNT_W-1:0]   words_q;
  logic [PW-1:0]      poll_q;
  logic [15:0]        rd_data_q;
  logic               rd_valid_q;
  logic [7:0]         status_q;
  logic [2:0]         err_q;

  logic accept;
  logic addr_inc;
  logic words_dec;
  logic poll_load;
  logic poll_dec;
  logic set_err_sr;
  logic set_err_to;
  logic set_err_ill;
  logic load_step;
  logic capture;
  logic [2:0]  step_code;
  logic [15:0] step_wdata;
  logic [17:0] step_bus;

  // Bus operation {OP, CMD_DATA_OUT} for a given command and step index.
  // PROGRAM/ERASE: steps 0-1 command, 2 read-status setup, 3 poll read,
  // 4 return to read-array mode.
  function automatic logic [17:0] step_op(input logic [2:0]  code,
                                          input logic [2:0]  step,
                                          input logic [15:0] wdata);
    logic [17:0] r;
    r = {OP_NONE, 16'h0000};
    case (code)
      C_RD_ARRAY:  r = (step == 3'd0) ? {OP_W, 16'h00FF} : {OP_R, 16'h0000};
      C_RD_STATUS: r = (step == 3'd0) ? {OP_W, 16'h0070} : {OP_R, 16'h0000};
      C_PROGRAM, C_ERASE: begin
        case (step)
          3'd0:    r = {OP_W, (code == C_PROGRAM) ? 16'h0040 : 16'h0020};
          3'd1:    r = {OP_W, (code == C_PROGRAM) ? wdata : 16'h00D0};
          3'd2:    r = {OP_W, 16'h0070};
          3'd3:    r = {OP_R, 16'h0000};
          default: r = {OP_W, 16'h00FF};
        endcase
      end
      C_UNLOCK:     r = (step == 3'd0) ? {OP_W, 16'h0060} : {OP_W, 16'h00D0};
      C_LOCK:       r = (step == 3'd0) ? {OP_W, 16'h0060} : {OP_W, 16'h0001};
      C_CLR_STATUS: r = {OP_W, 16'h0050};
      default:      r = {OP_NONE, 16'h0000};
    endcase
    return r;
  endfunction

  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    accept      = 1'b0;
    addr_inc    = 1'b0;
    words_dec   = 1'b0;
    poll_load   = 1'b0;
    poll_dec    = 1'b0;
    set_err_sr  = 1'b0;
    set_err_to  = 1'b0;
    set_err_ill = 1'b0;
    case (state_q)
      S_IDLE, S_FINISH: begin
        if (state_q == S_FINISH) state_d = S_IDLE;
        if (CMD_VALID) begin
          accept  = 1'b1;
          step_d  = 3'd0;
          state_d = (CMD_CODE == C_ILLEGAL) ? S_ILL : S_SETUP;
        end
      end
      S_ILL: begin
        set_err_ill = 1'b1;
        state_d     = S_FINISH;
      end
      S_SETUP:     if (!BPI_BUSY) state_d = S_ISSUE;
      S_ISSUE:     state_d = S_WAIT_ACK;
      S_WAIT_ACK:  if (BPI_BUSY) state_d = S_WAIT_DONE;
      S_WAIT_DONE: if (!BPI_BUSY) state_d = S_NEXT;
      S_NEXT: begin
        state_d = S_SETUP;
        step_d  = step_q + 3'd1;
        case (code_q)
          C_RD_ARRAY: begin
            if (step_q != 3'd0) begin
              if (words_q == CNT_W'(1)) begin
                state_d = S_FINISH;
              end else begin
                step_d    = step_q;
                addr_inc  = 1'b1;
                words_dec = 1'b1;
              end
            end
          end
          C_RD_STATUS, C_UNLOCK, C_LOCK: if (step_q != 3'd0) state_d = S_FINISH;
          C_PROGRAM, C_ERASE: begin
            case (step_q)
              3'd2: poll_load = 1'b1;
              3'd3: begin
                // Poll exit on SR[7]; otherwise retry until the budget runs out,
                // in which case the trailing read-array write is still issued.
                if (status_q[7]) begin
                  set_err_sr = |status_q[5:1];
                end else if (poll_q == PW'(1)) begin
                  set_err_to = 1'b1;
                end else begin
                  poll_dec = 1'b1;
                  step_d   = step_q;
                end
              end
              3'd4:    state_d = S_FINISH;
              default: ;
            endcase
          end
          default: state_d = S_FINISH;
        endcase
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The bus fields for a step are registered on entry to SETUP so they are
  // stable through WAIT_DONE.
  assign load_step  = (state_d == S_SETUP) && (state_q != S_SETUP);
  assign step_code  = accept ? CMD_CODE : code_q;
  assign step_wdata = accept ? CMD_DATA : data_q;
  assign step_bus   = step_op(step_code, step_d, step_wdata);

  assign capture = LOAD_DATA && (op_q == OP_R) &&
                   ((state_q == S_ISSUE) || (state_q == S_WAIT_ACK) ||
                    (state_q == S_WAIT_DONE));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= S_IDLE;
      code_q     <= 3'd0;
      step_q     <= 3'd0;
      addr_q     <= '0;
      data_q     <= '0;
      dout_q     <= '0;
      op_q       <= OP_NONE;
      words_q    <= '0;
      poll_q     <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      status_q   <= '0;
      err_q      <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      if (accept) begin
        code_q  <= CMD_CODE;
        addr_q  <= CMD_ADDR;
        data_q  <= CMD_DATA;
        words_q <= (CMD_CNT == '0) ? CNT_W'(1) : CMD_CNT;
        err_q   <= '0;
      end
      if (addr_inc)  addr_q  <= addr_q + 23'd1;
      if (words_dec) words_q <= words_q - CNT_W'(1);
      if (poll_load) poll_q <= PW'(POLL_MAX);
      else if (poll_dec) poll_q <= poll_q - PW'(1);
      if (set_err_sr)  err_q[0] <= 1'b1;
      if (set_err_to)  err_q[1] <= 1'b1;
      if (set_err_ill) err_q[2] <= 1'b1;
      if (load_step) begin
        op_q   <= step_bus[17:16];
        dout_q <= step_bus[15:0];
      end else if ((state_q == S_WAIT_DONE) && (state_d == S_NEXT)) begin
        op_q <= OP_NONE;
      end
      rd_valid_q <= capture && (code_q == C_RD_ARRAY);
      if (capture && (code_q == C_RD_ARRAY)) rd_data_q <= DATA_IN;
      if (capture && (code_q != C_RD_ARRAY)) status_q  <= DATA_IN[7:0];
    end
  end

  assign CMD_RDY      = (state_q == S_IDLE) || (state_q == S_FINISH);
  assign EXECUTE      = (state_q == S_ISSUE) || (state_q == S_WAIT_ACK);
  assign DONE         = (state_q == S_FINISH);
  assign ADDR         = addr_q;
  assign CMD_DATA_OUT = dout_q;
  assign OP           = op_q;
  assign RD_DATA      = rd_data_q;
  assign RD_VALID     = rd_valid_q;
  assign STATUS       = status_q;
  assign ERR          = {1'b0, err_q};

endmodule

// File: tb/tb_bpi_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// tb_bpi_cmd_sequencer
//   Directed bench for bpi_cmd_sequencer. A small interface model answers each
//   EXECUTE with a BUSY cycle (and LOAD_DATA/DATA_IN on reads) and checks every
//   bus operation against a queue of expected operations. Array words and
//   DONE/ERR/STATUS are checked against queues filled when stimulus is driven.
// -----------------------------------------------------------------------------
module tb_bpi_cmd_sequencer;

  logic        CLK;
  logic        RST;
  logic        CMD_VALID;
  logic        CMD_RDY;
  logic [2:0]  CMD_CODE;
  logic [22:0] CMD_ADDR;
  logic [15:0] CMD_DATA;
  logic [10:0] CMD_CNT;
  logic [22:0] ADDR;
  logic [15:0] CMD_DATA_OUT;
  logic [1:0]  OP;
  logic        EXECUTE;
  logic        BPI_BUSY;
  logic        LOAD_DATA;
  logic [15:0] DATA_IN;
  logic [15:0] RD_DATA;
  logic        RD_VALID;
  logic [7:0]  STATUS;
  logic        DONE;
  logic [3:0]  ERR;

  bpi_cmd_sequencer #(.CNT_W(11), .POLL_MAX(4)) dut (
    .CLK(CLK), .RST(RST),
    .CMD_VALID(CMD_VALID), .CMD_RDY(CMD_RDY), .CMD_CODE(CMD_CODE),
    .CMD_ADDR(CMD_ADDR), .CMD_DATA(CMD_DATA), .CMD_CNT(CMD_CNT),
    .ADDR(ADDR), .CMD_DATA_OUT(CMD_DATA_OUT), .OP(OP), .EXECUTE(EXECUTE),
    .BPI_BUSY(BPI_BUSY), .LOAD_DATA(LOAD_DATA), .DATA_IN(DATA_IN),
    .RD_DATA(RD_DATA), .RD_VALID(RD_VALID), .STATUS(STATUS),
    .DONE(DONE), .ERR(ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_assert = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int ack_delay = 0;

  logic [40:0] exp_op[$];   // {OP, ADDR, CMD_DATA_OUT}
  logic [15:0] rd_q[$];     // words the interface model returns on reads
  logic [15:0] exp_rd[$];   // expected RD_DATA words
  logic [11:0] exp_done[$]; // expected {ERR, STATUS} at DONE

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push_op(input logic [1:0] op, input logic [22:0] a, input logic [15:0] d);
    exp_op.push_back({op, a, d});
  endtask

  task automatic send(input logic [2:0] code, input logic [22:0] a,
                      input logic [15:0] d, input logic [10:0] cnt);
    int k;
    k = 0;
    while (CMD_RDY !== 1'b1 && k < 2000) begin
      @(negedge CLK);
      k++;
    end
    check("rdy_timeout", 64'(k < 2000), 64'(1));
    CMD_CODE  = code;
    CMD_ADDR  = a;
    CMD_DATA  = d;
    CMD_CNT   = cnt;
    CMD_VALID = 1'b1;
    @(negedge CLK);
    CMD_VALID = 1'b0;
  endtask

  task automatic wait_done();
    int start;
    int k;
    start = done_cnt;
    k = 0;
    while (done_cnt == start && k < 3000) begin
      @(negedge CLK);
      k++;
    end
    check("done_timeout", 64'(k < 3000), 64'(1));
  endtask

  // Interface model: sees EXECUTE, optionally delays BUSY, supplies read data.
  initial begin
    logic [40:0] seen;
    BPI_BUSY  = 1'b0;
    LOAD_DATA = 1'b0;
    DATA_IN   = 16'h0000;
    forever begin
      @(negedge CLK);
      if (EXECUTE === 1'b1 && RST === 1'b0) begin
        seen = {OP, ADDR, CMD_DATA_OUT};
        check("op_expected", 64'(exp_op.size() != 0), 64'(1));
        if (exp_op.size() != 0) check("bus_op", 64'(seen), 64'(exp_op.pop_front()));
        for (int i = 0; i < ack_delay; i++) begin
          @(negedge CLK);
          check("exec_held", 64'(EXECUTE), 64'(1));
        end
        BPI_BUSY = 1'b1;
        @(negedge CLK);
        if (seen[40:39] == 2'b10) begin
          check("rd_supply", 64'(rd_q.size() != 0), 64'(1));
          DATA_IN   = (rd_q.size() != 0) ? rd_q.pop_front() : 16'hDEAD;
          LOAD_DATA = 1'b1;
        end
        @(negedge CLK);
        LOAD_DATA = 1'b0;
        if (RST === 1'b0) begin
          check("op_stable", 64'({OP, ADDR, CMD_DATA_OUT}), 64'(seen));
          check("exec_cleared", 64'(EXECUTE), 64'(0));
        end
        BPI_BUSY = 1'b0;
      end
    end
  end

  // Output monitor for array words and completions.
  initial begin
    forever begin
      @(negedge CLK);
      if (RD_VALID === 1'b1) begin
        check("rd_expected", 64'(exp_rd.size() != 0), 64'(1));
        if (exp_rd.size() != 0) check("rd_data", 64'(RD_DATA), 64'(exp_rd.pop_front()));
      end
      if (DONE === 1'b1) begin
        done_cnt++;
        check("done_expected", 64'(exp_done.size() != 0), 64'(1));
        if (exp_done.size() != 0) check("done_err_status", 64'({ERR, STATUS}), 64'(exp_done.pop_front()));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int done_before;
    RST = 1'b1;
    CMD_VALID = 1'b0;
    CMD_CODE = 3'd0;
    CMD_ADDR = '0;
    CMD_DATA = '0;
    CMD_CNT  = '0;
    repeat (3) @(negedge CLK);
    check("rst_rdy", 64'(CMD_RDY), 64'(1));
    check("rst_op", 64'(OP), 64'(0));
    check("rst_exec", 64'(EXECUTE), 64'(0));
    check("rst_done", 64'(DONE), 64'(0));
    check("rst_err", 64'(ERR), 64'(0));
    check("rst_addr", 64'(ADDR), 64'(0));
    check("rst_dout", 64'(CMD_DATA_OUT), 64'(0));
    check("rst_rdv", 64'({RD_VALID, RD_DATA}), 64'(0));
    check("rst_status", 64'(STATUS), 64'(0));
    RST = 1'b0;
    @(negedge CLK);
    check("post_rst_rdy", 64'(CMD_RDY), 64'(1));

    // RD_ARRAY across the address wrap
    push_op(2'b01, 23'h7FFFFE, 16'h00FF);
    push_op(2'b10, 23'h7FFFFE, 16'h0000);
    push_op(2'b10, 23'h7FFFFF, 16'h0000);
    push_op(2'b10, 23'h000000, 16'h0000);
    rd_q.push_back(16'h00A1); rd_q.push_back(16'h00A2); rd_q.push_back(16'h00A3);
    exp_rd.push_back(16'h00A1); exp_rd.push_back(16'h00A2); exp_rd.push_back(16'h00A3);
    exp_done.push_back({4'h0, 8'h00});
    send(3'd0, 23'h7FFFFE, 16'h0000, 11'd3);
    wait_done();

    // PROGRAM, poll succeeds on the third read
    push_op(2'b01, 23'h001000, 16'h0040);
    push_op(2'b01, 23'h001000, 16'hBEEF);
    push_op(2'b01, 23'h001000, 16'h0070);
    repeat (3) push_op(2'b10, 23'h001000, 16'h0000);
    push_op(2'b01, 23'h001000, 16'h00FF);
    rd_q.push_back(16'h0000); rd_q.push_back(16'h0000); rd_q.push_back(16'h0080);
    exp_done.push_back({4'h0, 8'h80});
    send(3'd2, 23'h001000, 16'hBEEF, 11'd0);
    wait_done();

    // ERASE with SR[5] set
    push_op(2'b01, 23'h002000, 16'h0020);
    push_op(2'b01, 23'h002000, 16'h00D0);
    push_op(2'b01, 23'h002000, 16'h0070);
    push_op(2'b10, 23'h002000, 16'h0000);
    push_op(2'b01, 23'h002000, 16'h00FF);
    rd_q.push_back(16'h00A0);
    exp_done.push_back({4'h1, 8'hA0});
    send(3'd3, 23'h002000, 16'h0000, 11'd0);
    wait_done();

    // next command accepted; ERR cleared
    push_op(2'b01, 23'h002000, 16'h0050);
    exp_done.push_back({4'h0, 8'hA0});
    send(3'd6, 23'h002000, 16'h0000, 11'd0);
    wait_done();

    // PROGRAM with poll timeout (POLL_MAX=4)
    push_op(2'b01, 23'h004000, 16'h0040);
    push_op(2'b01, 23'h004000, 16'h1234);
    push_op(2'b01, 23'h004000, 16'h0070);
    repeat (4) push_op(2'b10, 23'h004000, 16'h0000);
    push_op(2'b01, 23'h004000, 16'h00FF);
    repeat (4) rd_q.push_back(16'h0000);
    exp_done.push_back({4'h2, 8'h00});
    send(3'd2, 23'h004000, 16'h1234, 11'd0);
    wait_done();

    // illegal code: DONE two cycles after acceptance, no bus op
    exp_done.push_back({4'h4, 8'h00});
    send(3'd7, 23'h000123, 16'h0000, 11'd0);
    check("ill_done_early", 64'(DONE), 64'(0));
    check("ill_rdy_low", 64'(CMD_RDY), 64'(0));
    @(negedge CLK);
    check("ill_done", 64'(DONE), 64'(1));
    check("ill_err", 64'(ERR), 64'(4));
    check("ill_rdy", 64'(CMD_RDY), 64'(1));

    // UNLOCK and LOCK
    push_op(2'b01, 23'h005000, 16'h0060);
    push_op(2'b01, 23'h005000, 16'h00D0);
    exp_done.push_back({4'h0, 8'h00});
    send(3'd4, 23'h005000, 16'h0000, 11'd0);
    wait_done();
    push_op(2'b01, 23'h006000, 16'h0060);
    push_op(2'b01, 23'h006000, 16'h0001);
    exp_done.push_back({4'h0, 8'h00});
    send(3'd5, 23'h006000, 16'h0000, 11'd0);
    wait_done();

    // RD_ARRAY with count 0 reads one word
    push_op(2'b01, 23'h000010, 16'h00FF);
    push_op(2'b10, 23'h000010, 16'h0000);
    rd_q.push_back(16'h1234);
    exp_rd.push_back(16'h1234);
    exp_done.push_back({4'h0, 8'h00});
    send(3'd0, 23'h000010, 16'h0000, 11'd0);
    wait_done();

    // RD_STATUS with slow BUSY acknowledge; CMD_VALID during the op is ignored
    ack_delay = 5;
    push_op(2'b01, 23'h000ABC, 16'h0070);
    push_op(2'b10, 23'h000ABC, 16'h0000);
    rd_q.push_back(16'h005A);
    exp_done.push_back({4'h0, 8'h5A});
    send(3'd1, 23'h000ABC, 16'h0000, 11'd0);
    CMD_VALID = 1'b1;
    CMD_CODE  = 3'd6;
    for (int i = 0; i < 4; i++) begin
      check("rdy_low_in_op", 64'(CMD_RDY), 64'(0));
      @(negedge CLK);
    end
    CMD_VALID = 1'b0;
    wait_done();
    ack_delay = 0;

    // reset during WAIT_DONE of an erase
    push_op(2'b01, 23'h003000, 16'h0020);
    send(3'd3, 23'h003000, 16'h0000, 11'd0);
    k = 0;
    while (EXECUTE !== 1'b1 && k < 100) begin
      @(negedge CLK);
      k++;
    end
    check("erase_exec_seen", 64'(k < 100), 64'(1));
    @(posedge CLK);
    @(posedge CLK);
    #2;
    check("pre_rst_op", 64'(OP), 64'(1));
    check("pre_rst_exec", 64'(EXECUTE), 64'(0));
    done_before = done_cnt;
    RST = 1'b1;
    #1;
    check("mid_rst_op", 64'(OP), 64'(0));
    check("mid_rst_exec", 64'(EXECUTE), 64'(0));
    check("mid_rst_rdy", 64'(CMD_RDY), 64'(1));
    check("mid_rst_addr", 64'(ADDR), 64'(0));
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    repeat (5) @(negedge CLK);
    check("no_done_after_rst", 64'(done_cnt), 64'(done_before));

    // recovery after reset
    push_op(2'b01, 23'h007000, 16'h0050);
    exp_done.push_back({4'h0, 8'h00});
    send(3'd6, 23'h007000, 16'h0000, 11'd0);
    wait_done();
    repeat (5) @(negedge CLK);

    check("ops_left", 64'(exp_op.size()), 64'(0));
    check("rd_left", 64'(exp_rd.size()), 64'(0));
    check("done_left", 64'(exp_done.size()), 64'(0));
    check("supply_left", 64'(rd_q.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
